// File: rtl/mem_pkg.sv
// mem_pkg
//   Types and constants shared by the line controller, the caches and the
//   RAM wrapper: physical word-address width, line width, the line type,
//   the controller state encoding and the requester identity.
package mem_pkg;

   localparam int PADDR_W = 20;
   localparam int LINE_W  = 128;

   typedef logic [LINE_W-1:0]  line_t;
   typedef logic [PADDR_W-1:0] paddr_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } mem_state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } mem_req_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Two-way round-robin arbiter between the icache and dcache miss ports.
//   Ports:
//     clk, reset   core clock, asynchronous active-low reset
//     i_req_ic     icache request present
//     i_req_dc     dcache request present
//     i_update     one-cycle strobe: record i_winner as the last grant
//     i_winner     requester that just completed its transaction
//     o_valid      at least one request present
//     o_grant      requester to grant this cycle (meaningful with o_valid)
module mem_rr_arbiter
   import mem_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     i_req_ic,
   input  logic     i_req_dc,
   input  logic     i_update,
   input  mem_req_t i_winner,
   output logic     o_valid,
   output mem_req_t o_grant
);

   mem_req_t r_last_grant;
   // Until the first transaction completes nobody has "won last time", so a
   // tie out of reset goes to the icache.
   logic     r_no_history;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_grant <= REQ_IC;
         r_no_history <= 1'b1;
      end else if (i_update) begin
         r_last_grant <= i_winner;
         r_no_history <= 1'b0;
      end
   end

   // NOTE: every output of this always_comb gets a default first, so no
   // path through the block can leave a value held (which would be a latch).
   always_comb begin
      o_valid = i_req_ic | i_req_dc;
      o_grant = REQ_IC;
      if (i_req_ic && i_req_dc) begin
         if (!r_no_history && (r_last_grant == REQ_IC)) begin
            o_grant = REQ_DC;
         end
      end else if (i_req_dc) begin
         o_grant = REQ_DC;
      end
   end

endmodule

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl
//   Sole master of the RAM line port. Arbitrates between the icache and
//   dcache, runs one 128-bit line read or write at a time with a fixed
//   MEM_LATENCY wait, and returns the fill line / completion to the winner.
//   Ports:
//     clk, reset                      core clock, asynchronous active-low reset
//     ic_req, ic_addr                 icache line-read request (held until ack)
//     ic_ack, ic_rdata                completion pulse and fill line
//     dc_req, dc_we, dc_addr,         dcache read/write request (held until ack)
//     dc_wdata                        writeback line
//     dc_ack, dc_rdata                completion pulse and fill line
//     data_requested, data_returned   RAM read address (word) and read data
//     where_to_write, data_to_write,  RAM write line index, data and strobe
//     write_to_mem
//     busy                            a transaction is in flight
module mem_line_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 5   // legal range 1..15
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                ic_req,
   input  logic [PADDR_W-1:0]  ic_addr,
   output logic                ic_ack,
   output logic [LINE_W-1:0]   ic_rdata,
   input  logic                dc_req,
   input  logic                dc_we,
   input  logic [PADDR_W-1:0]  dc_addr,
   input  logic [LINE_W-1:0]   dc_wdata,
   output logic                dc_ack,
   output logic [LINE_W-1:0]   dc_rdata,
   output logic [PADDR_W-1:0]  data_requested,
   input  logic [LINE_W-1:0]   data_returned,
   output logic [PADDR_W-1:0]  where_to_write,
   output logic [LINE_W-1:0]   data_to_write,
   output logic                write_to_mem,
   output logic                busy
);

   localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

   mem_state_t r_state, w_next_state;
   logic [3:0] r_wait_cnt;
   mem_req_t   r_winner;
   paddr_t     r_data_requested;
   paddr_t     r_where_to_write;
   line_t      r_data_to_write;
   line_t      r_ic_rdata;
   line_t      r_dc_rdata;

   logic       w_arb_valid;
   mem_req_t   w_arb_grant;
   logic       w_grant;
   logic       w_sel_we;
   paddr_t     w_sel_addr;
   logic       w_wait_done;
   logic       w_in_wait;
   logic       w_unused_addr_bits;

   // Word-select bits of the request addresses are irrelevant to line accesses.
   assign w_unused_addr_bits = ^{ic_addr[1:0], dc_addr[1:0]};

   mem_rr_arbiter u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req_ic (ic_req),
      .i_req_dc (dc_req),
      .i_update (r_state == DONE),
      .i_winner (r_winner),
      .o_valid  (w_arb_valid),
      .o_grant  (w_arb_grant)
   );

   assign w_grant     = (r_state == IDLE) && w_arb_valid;
   assign w_sel_we    = (w_arb_grant == REQ_DC) && dc_we;
   assign w_sel_addr  = (w_arb_grant == REQ_DC) ? dc_addr : ic_addr;
   assign w_wait_done = (r_wait_cnt == 4'd0);
   assign w_in_wait   = (r_state == RD_WAIT) || (r_state == WR_WAIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (w_grant) w_next_state = w_sel_we ? WR_WAIT : RD_WAIT;
         RD_WAIT: if (w_wait_done) w_next_state = DONE;
         WR_WAIT: if (w_wait_done) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Request fields are captured only at grant; the RAM-facing registers
   // therefore stay stable for the whole wait phase and hold in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wait_cnt       <= '0;
         r_winner         <= REQ_IC;
         r_data_requested <= '0;
         r_where_to_write <= '0;
         r_data_to_write  <= '0;
         r_ic_rdata       <= '0;
         r_dc_rdata       <= '0;
      end else begin
         if (w_grant) begin
            r_winner   <= w_arb_grant;
            r_wait_cnt <= WAIT_LOAD;
            if (w_sel_we) begin
               r_where_to_write <= {2'b00, w_sel_addr[PADDR_W-1:2]};
               r_data_to_write  <= dc_wdata;
            end else begin
               r_data_requested <= {w_sel_addr[PADDR_W-1:2], 2'b00};
            end
         end else if (w_in_wait && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end

         if ((r_state == RD_WAIT) && w_wait_done) begin
            if (r_winner == REQ_DC) r_dc_rdata <= data_returned;
            else                    r_ic_rdata <= data_returned;
         end
      end
   end

   assign ic_ack         = (r_state == DONE) && (r_winner == REQ_IC);
   assign dc_ack         = (r_state == DONE) && (r_winner == REQ_DC);
   assign ic_rdata       = r_ic_rdata;
   assign dc_rdata       = r_dc_rdata;
   assign data_requested = r_data_requested;
   assign where_to_write = r_where_to_write;
   assign data_to_write  = r_data_to_write;
   // Decoded from the state register so an asynchronous reset drops it at once.
   assign write_to_mem   = (r_state == WR_WAIT) && w_wait_done;
   assign busy           = (r_state != IDLE);

endmodule
